// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: access kinds seen by the matcher and the check-arbiter FSM states.
package rv_iopmp_pkg;

  typedef enum logic [1:0] {
    ACCESS_NONE    = 2'd0,
    ACCESS_READ    = 2'd1,
    ACCESS_WRITE   = 2'd2,
    ACCESS_EXECUTE = 2'd3
  } access_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } arb_state_e;

endpackage

// File: rtl/rv_iopmp_rr_arbiter.sv
// Combinational round-robin pick: first requesting index at or after ptr, wrapping.
module rv_iopmp_rr_arbiter #(
  parameter int NUM_CHANNELS = 2,
  localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic [NUM_CHANNELS-1:0] req,
  input  logic [IDX_W-1:0]        ptr,
  output logic [NUM_CHANNELS-1:0] grant,
  output logic [IDX_W-1:0]        idx,
  output logic                    any
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    // Scan farthest-first so the last hit is the one closest to the pointer.
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_CHANNELS) cand = cand - NUM_CHANNELS;
      if (req[IDX_W'(cand)]) begin
        idx = IDX_W'(cand);
        any = 1'b1;
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/rv_iopmp_check_arbiter.sv
// Shares one IOPMP matching engine among several requesters: round-robin grant,
// request latch, response routing and a watchdog that denies unanswered checks.
module rv_iopmp_check_arbiter
  import rv_iopmp_pkg::*;
#(
  parameter int NUM_CHANNELS   = 2,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int SID_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int NBW = $clog2(DATA_WIDTH / 8) + 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NUM_CHANNELS-1:0]                chan_req_valid_i,
  output logic [NUM_CHANNELS-1:0]                chan_req_ready_o,
  input  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] chan_addr_i,
  input  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] chan_total_length_i,
  input  logic [NUM_CHANNELS-1:0][NBW-1:0]       chan_num_bytes_i,
  input  logic [NUM_CHANNELS-1:0][SID_WIDTH-1:0] chan_sid_i,
  input  access_t [NUM_CHANNELS-1:0]             chan_access_type_i,
  output logic [NUM_CHANNELS-1:0]                chan_rsp_valid_o,
  output logic [NUM_CHANNELS-1:0]                chan_rsp_allow_o,
  output logic [NUM_CHANNELS-1:0]                chan_rsp_timeout_o,
  output logic                                   transaction_en_o,
  output logic [ADDR_WIDTH-1:0]                  addr_o,
  output logic [ADDR_WIDTH-1:0]                  total_length_o,
  output logic [NBW-1:0]                         num_bytes_o,
  output logic [SID_WIDTH-1:0]                   sid_o,
  output access_t                                access_type_o,
  input  logic                                   ready_i,
  input  logic                                   valid_i,
  input  logic                                   allow_transaction_i,
  output logic                                   busy_o,
  output logic                                   timeout_o
);

  localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_e state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, idx_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q, len_q;
  logic [NBW-1:0]        nb_q;
  logic [SID_WIDTH-1:0]  sid_q;
  access_t               acc_q;
  logic                  allow_q, tmo_q;

  logic [NUM_CHANNELS-1:0] arb_grant;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_any;
  logic                    wd_expire;

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] g);
    if (NUM_CHANNELS == 1) return '0;
    return (int'(g) == NUM_CHANNELS - 1) ? '0 : g + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  rv_iopmp_rr_arbiter #(
    .NUM_CHANNELS(NUM_CHANNELS)
  ) u_rr (
    .req  (chan_req_valid_i),
    .ptr  (ptr_q),
    .grant(arb_grant),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  assign wd_expire = WD_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      nb_q    <= '0;
      sid_q   <= '0;
      acc_q   <= ACCESS_NONE;
      allow_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            idx_q  <= arb_idx;
            ptr_q  <= ptr_after(arb_idx);
            addr_q <= chan_addr_i[arb_idx];
            len_q  <= chan_total_length_i[arb_idx];
            nb_q   <= chan_num_bytes_i[arb_idx];
            sid_q  <= chan_sid_i[arb_idx];
            acc_q  <= chan_access_type_i[arb_idx];
          end
        end
        ISSUE: if (ready_i) cnt_q <= '0;
        WAIT: begin
          // A result arriving in the expiry cycle still counts as a real answer.
          if (valid_i) begin
            allow_q <= allow_transaction_i;
            tmo_q   <= 1'b0;
          end else if (wd_expire) begin
            allow_q <= 1'b0;
            tmo_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_sat_inc(cnt_q);
          end
        end
        RESP: if (tmo_q) cnt_q <= '0;
        DRAIN: if (!valid_i && !wd_expire) cnt_q <= cnt_sat_inc(cnt_q);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d            = state_q;
    chan_req_ready_o   = '0;
    chan_rsp_valid_o   = '0;
    chan_rsp_allow_o   = '0;
    chan_rsp_timeout_o = '0;
    unique case (state_q)
      IDLE:    if (arb_any) state_d = ISSUE;
      ISSUE:   if (ready_i) state_d = WAIT;
      WAIT:    if (valid_i || wd_expire) state_d = RESP;
      RESP:    state_d = tmo_q ? DRAIN : IDLE;
      DRAIN:   if (valid_i || wd_expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Grant is combinational from the request lines, so hold it off while in reset.
    if (state_q == IDLE && rst_ni) chan_req_ready_o = arb_grant;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (state_q == RESP && idx_q == IDX_W'(i)) begin
        chan_rsp_valid_o[i]   = 1'b1;
        chan_rsp_allow_o[i]   = allow_q;
        chan_rsp_timeout_o[i] = tmo_q;
      end
    end
  end

  assign transaction_en_o = (state_q == ISSUE);
  assign busy_o           = (state_q != IDLE);
  assign timeout_o        = (state_q == RESP) && tmo_q;
  assign addr_o           = addr_q;
  assign total_length_o   = len_q;
  assign num_bytes_o      = nb_q;
  assign sid_o            = sid_q;
  assign access_type_o    = acc_q;

endmodule

// File: tb/tb_rv_iopmp_check_arbiter.sv
// Randomized bench for rv_iopmp_check_arbiter against a transaction-level reference model.
module tb_rv_iopmp_check_arbiter;
  import rv_iopmp_pkg::*;

  localparam int N   = 3;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int SW  = 8;
  localparam int T   = 8;
  localparam int NBW = $clog2(DW / 8) + 1;

  logic clk = 1'b0;
  logic rst_ni;
  logic [N-1:0] chan_req_valid, chan_req_ready, chan_rsp_valid, chan_rsp_allow, chan_rsp_timeout;
  logic [N-1:0][AW-1:0] chan_addr, chan_len;
  logic [N-1:0][NBW-1:0] chan_nb;
  logic [N-1:0][SW-1:0] chan_sid;
  access_t [N-1:0] chan_acc;
  logic transaction_en, ready_i, valid_i, allow_i, busy, timeout;
  logic [AW-1:0] addr_o, len_o;
  logic [NBW-1:0] nb_o;
  logic [SW-1:0] sid_o;
  access_t acc_o;

  int n_tests = 0;
  int n_fail  = 0;
  int model_ptr = 0;

  always #5 clk = ~clk;

  rv_iopmp_check_arbiter #(
    .NUM_CHANNELS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SID_WIDTH(SW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .chan_req_valid_i(chan_req_valid), .chan_req_ready_o(chan_req_ready),
    .chan_addr_i(chan_addr), .chan_total_length_i(chan_len),
    .chan_num_bytes_i(chan_nb), .chan_sid_i(chan_sid), .chan_access_type_i(chan_acc),
    .chan_rsp_valid_o(chan_rsp_valid), .chan_rsp_allow_o(chan_rsp_allow),
    .chan_rsp_timeout_o(chan_rsp_timeout),
    .transaction_en_o(transaction_en), .addr_o(addr_o), .total_length_o(len_o),
    .num_bytes_o(nb_o), .sid_o(sid_o), .access_type_o(acc_o),
    .ready_i(ready_i), .valid_i(valid_i), .allow_transaction_i(allow_i),
    .busy_o(busy), .timeout_o(timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference arbitration: first requester at or after the pointer, wrapping.
  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int c;
      c = (model_ptr + k) % N;
      if (chan_req_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_req(input int ch, input logic [63:0] a, input logic [63:0] l,
                         input int nb, input int sid, input access_t acc);
    chan_addr[ch]      = a;
    chan_len[ch]       = l;
    chan_nb[ch]        = NBW'(nb);
    chan_sid[ch]       = SW'(sid);
    chan_acc[ch]       = acc;
    chan_req_valid[ch] = 1'b1;
  endtask

  task automatic rand_req(input int ch);
    set_req(ch, {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(1, 8)),
            int'($urandom_range(0, 255)), $urandom_range(0, 1) ? ACCESS_WRITE : ACCESS_READ);
  endtask

  // Entered just after a negedge with the DUT idle; returns at the same point.
  // vdelay >= T means the matcher never answers; late >= T means no late answer in drain.
  task automatic run_txn(input int stall, input int vdelay, input bit alw, input int late,
                         output int g);
    logic [63:0] ea, el, en, es, eacc, onehot;
    bit tmo;
    int nw, nd;
    ready_i = 1'b0;
    valid_i = 1'($urandom_range(0, 1));
    allow_i = 1'b1;
    #1;
    g = model_grant();
    if (g < 0) begin
      check("req_pending", 64'(chan_req_valid), 64'(1));
      return;
    end
    onehot = 64'(1) << g;
    check("idle_busy", 64'(busy), 0);
    check("req_ready", 64'(chan_req_ready), onehot);
    check("idle_txn_en", 64'(transaction_en), 0);
    check("idle_rsp_valid", 64'(chan_rsp_valid), 0);
    ea = chan_addr[g]; el = chan_len[g]; en = 64'(chan_nb[g]);
    es = 64'(chan_sid[g]); eacc = 64'(chan_acc[g]);
    model_ptr = (g + 1) % N;

    for (int i = 0; i <= stall; i++) begin
      @(negedge clk);
      if (i == 0) chan_req_valid[g] = 1'b0;
      ready_i = (i == stall);
      valid_i = 1'($urandom_range(0, 1));
      #1;
      check("issue_txn_en", 64'(transaction_en), 1);
      check("issue_addr", addr_o, ea);
      check("issue_len", len_o, el);
      check("issue_nb", 64'(nb_o), en);
      check("issue_sid", 64'(sid_o), es);
      check("issue_acc", 64'(acc_o), eacc);
      check("issue_req_ready", 64'(chan_req_ready), 0);
      check("issue_timeout", 64'(timeout), 0);
    end

    tmo = (vdelay >= T);
    nw  = tmo ? T : vdelay + 1;
    for (int i = 0; i < nw; i++) begin
      @(negedge clk);
      ready_i = 1'b0;
      valid_i = (!tmo && i == vdelay);
      allow_i = valid_i ? alw : 1'($urandom_range(0, 1));
      #1;
      check("wait_txn_en", 64'(transaction_en), 0);
      check("wait_rsp_valid", 64'(chan_rsp_valid), 0);
      check("wait_timeout", 64'(timeout), 0);
      check("wait_busy", 64'(busy), 1);
    end

    @(negedge clk);
    valid_i = 1'($urandom_range(0, 1));
    allow_i = 1'($urandom_range(0, 1));
    #1;
    check("rsp_valid", 64'(chan_rsp_valid), onehot);
    check("rsp_allow", 64'(chan_rsp_allow), (!tmo && alw) ? onehot : 0);
    check("rsp_timeout", 64'(chan_rsp_timeout), tmo ? onehot : 0);
    check("timeout_pulse", 64'(timeout), 64'(tmo));

    if (tmo) begin
      nd = (late < T) ? late + 1 : T;
      for (int i = 0; i < nd; i++) begin
        @(negedge clk);
        valid_i = (late < T && i == late);
        allow_i = 1'b1;
        #1;
        check("drain_busy", 64'(busy), 1);
        check("drain_rsp_valid", 64'(chan_rsp_valid), 0);
        check("drain_timeout", 64'(timeout), 0);
        check("drain_txn_en", 64'(transaction_en), 0);
      end
    end
    @(negedge clk);
    valid_i = 1'b0;
    ready_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int g, stall, vdelay, late;
    rst_ni = 1'b0;
    chan_req_valid = '0;
    chan_addr = '0; chan_len = '0; chan_nb = '0; chan_sid = '0;
    for (int c = 0; c < N; c++) chan_acc[c] = ACCESS_READ;
    ready_i = 1'b0; valid_i = 1'b0; allow_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 64'(busy), 0);
    check("rst_txn_en", 64'(transaction_en), 0);
    check("rst_rsp_valid", 64'(chan_rsp_valid), 0);
    check("rst_addr", addr_o, 0);
    check("rst_timeout", 64'(timeout), 0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    // Two channels held valid for four checks alternate.
    set_req(0, 64'h2000, 64'd32, 4, 7, ACCESS_READ);
    set_req(1, 64'h3000, 64'd16, 2, 9, ACCESS_WRITE);
    for (int i = 0; i < 4; i++) begin
      run_txn(0, 1, 1'b1, T, g);
      set_req(g, 64'h4000 + 64'(i), 64'(i + 1), 8, 20 + i, ACCESS_WRITE);
    end
    chan_req_valid = '0;

    // Single check, answered one cycle after acceptance.
    set_req(0, 64'h1000, 64'd64, 8, 3, ACCESS_READ);
    run_txn(0, 0, 1'b1, T, g);

    // Matcher never answers: watchdog deny, full drain.
    set_req(0, 64'h5000, 64'd8, 1, 4, ACCESS_READ);
    run_txn(0, T, 1'b1, T, g);

    // Watchdog deny, late answer in drain, then a normal check on ch1.
    set_req(0, 64'h6000, 64'd8, 1, 5, ACCESS_WRITE);
    run_txn(0, T + 1, 1'b1, 3, g);
    set_req(1, 64'h7000, 64'd24, 8, 6, ACCESS_READ);
    run_txn(0, 2, 1'b1, T, g);

    // Answer in the expiry cycle itself wins over the watchdog.
    set_req(2, 64'h7800, 64'd8, 2, 1, ACCESS_READ);
    run_txn(0, T - 1, 1'b1, T, g);

    // Long acceptance stall, then answered with deny.
    set_req(1, 64'h8000, 64'd128, 8, 11, ACCESS_WRITE);
    run_txn(20, 1, 1'b0, T, g);

    for (int it = 0; it < 40; it++) begin
      for (int c = 0; c < N; c++)
        if (!chan_req_valid[c] && $urandom_range(0, 1) == 1) rand_req(c);
      if (chan_req_valid == '0) rand_req(int'($urandom_range(0, N - 1)));
      stall  = int'($urandom_range(0, 3));
      vdelay = int'($urandom_range(0, T + 1));
      late   = int'($urandom_range(0, T));
      run_txn(stall, vdelay, 1'($urandom_range(0, 1)), late, g);
    end

    // Reset while waiting for the matcher drops the check.
    chan_req_valid = '0;
    set_req(0, 64'h9000, 64'd8, 8, 2, ACCESS_READ);
    model_ptr = 1;
    @(negedge clk);
    chan_req_valid = '0;
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    #1;
    check("pre_rst_busy", 64'(busy), 1);
    rst_ni = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 0);
    check("midrst_txn_en", 64'(transaction_en), 0);
    check("midrst_rsp_valid", 64'(chan_rsp_valid), 0);
    check("midrst_addr", addr_o, 0);
    check("midrst_sid", 64'(sid_o), 0);
    model_ptr = 0;
    @(negedge clk);
    set_req(0, 64'hA000, 64'd8, 8, 12, ACCESS_READ);
    set_req(1, 64'hB000, 64'd8, 8, 13, ACCESS_WRITE);
    #1;
    check("midrst_req_ready", 64'(chan_req_ready), 0);
    @(negedge clk);
    rst_ni = 1'b1;
    run_txn(0, 0, 1'b1, T, g);
    run_txn(0, 0, 1'b0, T, g);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
